add_sub_serial: RTL and testbench

ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

---
 rtl/add_sub_serial.sv | 120 ++++++++++++
 tb/tb_add_sub_serial.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// add_sub_serial
//   Chunk-serial adder/subtractor. An accepted request latches the operands
//   and then adds one CHUNK-bit slice per clock, LSB slice first, with the
//   carry between slices held in a register. The result and flags update
//   together when the last slice finishes. They then hold until the next
//   result is ready.
//
// Parameters
//   WIDTH     operand/result width (must be a multiple of CHUNK)
//   CHUNK     bits processed per clock
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request a new operation (taken only when busy = 0)
//   sub       0 = A+B+C, 1 = A-B-C
//   A, B      operands
//   C         carry-in (add) / borrow-in (sub)
//   busy      operation in progress
//   done      one-cycle pulse when the result registers update
//   sum       result modulo 2^WIDTH
//   carry     raw carry out of the MSB (for sub: 1 = no borrow)
//   overflow  two's-complement signed overflow
//   zero      sum == 0
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic             cin_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             accept, last_slice;

  // Operand registers shift right each RUN cycle, so the active slice is
  // always the low CHUNK bits. Result slices enter the accumulator from the
  // top, so after N shifts the accumulator is in natural bit order.
  always_comb begin
    accept     = start && (state != RUN);
    last_slice = (state == RUN) && (cnt_q == LAST);
    {slice_cout, slice_sum} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, cin_q};
    acc_next = (acc_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_q == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else if (accept) begin
      // Subtraction is performed as A + ~B + ~C.
      a_q   <= A;
      b_q   <= B ^ {WIDTH{sub}};
      cin_q <= C ^ sub;
      cnt_q <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      cin_q <= slice_cout;
      acc_q <= acc_next;
      cnt_q <= last_slice ? '0 : cnt_q + CW'(1);
      if (last_slice) begin
        sum      <= acc_next;
        carry    <= slice_cout;
        // Carry into the MSB is recovered as a ^ b ^ s at that bit.
        overflow <= slice_cout ^ (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_sum[CHUNK-1]);
        zero     <= (acc_next == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_add_sub_serial.sv
module tb_add_sub_serial;

  logic        clk;
  logic        reset_n;

  logic        start, sub, C;
  logic [15:0] A, B;
  logic        busy, done, carry, overflow, zero;
  logic [15:0] sum;

  logic        start8, sub8, C8;
  logic [7:0]  A8, B8;
  logic        busy8, done8, carry8, overflow8, zero8;
  logic [7:0]  sum8;

  int checks   = 0;
  int failures = 0;

  logic [15:0] last16 = '0;
  logic [7:0]  last8  = '0;

  add_sub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub),
    .A(A), .B(B), .C(C),
    .busy(busy), .done(done), .sum(sum), .carry(carry),
    .overflow(overflow), .zero(zero)
  );

  add_sub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub8),
    .A(A8), .B(B8), .C(C8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8),
    .overflow(overflow8), .zero(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit c, input bit s, output longint r,
                                output bit cy, output bit ov, output bit z);
    longint lim, full, sa, sb, sr, ci;
    lim = longint'(1) << w;
    ci  = c ? 1 : 0;
    sa  = (a >= lim / 2) ? a - lim : a;
    sb  = (b >= lim / 2) ? b - lim : b;
    if (!s) begin
      full = a + b + ci;
      sr   = sa + sb + ci;
      cy   = (full >= lim);
    end else begin
      full = a - b - ci;
      sr   = sa - sb - ci;
      cy   = (full >= 0);
    end
    r  = full & (lim - 1);
    ov = (sr >= lim / 2) || (sr < -(lim / 2));
    z  = (r == 0);
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit c,
                      input bit s, input bit poke, input string tag);
    longint r; bit cy, ov, z; int n;
    model(16, a, b, c, s, r, cy, ov, z);
    @(negedge clk);
    A = a; B = b; C = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); C = 1'($urandom); sub = 1'($urandom);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_hold"}, sum, last16);
    n = 0;
    while (!done && n < 20) begin
      start = (poke && n == 0);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, r[15:0]);
    chk({tag, "_carry"}, carry, cy);
    chk({tag, "_ovf"}, overflow, ov);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_busy_done"}, busy, 0);
    last16 = r[15:0];
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit c,
                     input bit s, input string tag);
    longint r; bit cy, ov, z; int n;
    model(8, a, b, c, s, r, cy, ov, z);
    @(negedge clk);
    A8 = a; B8 = b; C8 = c; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    chk({tag, "_hold"}, sum8, last8);
    n = 0;
    while (!done8 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_sum"}, sum8, r[7:0]);
    chk({tag, "_carry"}, carry8, cy);
    chk({tag, "_ovf"}, overflow8, ov);
    chk({tag, "_zero"}, zero8, z);
    last8 = r[7:0];
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 0);
  endtask

  initial begin
    longint r1, r2; bit cy1, ov1, z1, cy2, ov2, z2;
    int n, pulses;

    reset_n = 1'b1;
    start = 0; sub = 0; C = 0; A = '0; B = '0;
    start8 = 0; sub8 = 0; C8 = 0; A8 = '0; B8 = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 1);
    chk("rst8_zero", zero8, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    op16(16'h1234, 16'h4321, 0, 0, 0, "add_basic");
    op16(16'hFFFF, 16'h0001, 0, 0, 0, "add_wrap");
    op16(16'h7FFF, 16'h0001, 0, 0, 0, "add_ovf");
    op16(16'h0005, 16'h0007, 0, 1, 0, "sub_neg");
    op16(16'h8000, 16'h0001, 0, 1, 0, "sub_ovf");
    op16(16'h0005, 16'h0002, 1, 1, 0, "sub_borrow_in");
    op16(16'hABCD, 16'h1111, 1, 0, 1, "start_in_run");
    for (int i = 0; i < 30; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");

    // Back-to-back: start held high across DONE.
    model(16, 16'h0F0F, 16'h0101, 0, 0, r1, cy1, ov1, z1);
    model(16, 16'h0100, 16'h0200, 0, 1, r2, cy2, ov2, z2);
    @(negedge clk);
    A = 16'h0F0F; B = 16'h0101; C = 0; sub = 0; start = 1'b1;
    n = 0;
    while (!done && n < 20) begin n++; @(negedge clk); end
    chk("b2b_lat1", n, 5);
    chk("b2b_sum1", sum, r1[15:0]);
    A = 16'h0100; B = 16'h0200; C = 0; sub = 1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_hold", sum, r1[15:0]);
    n = 1;
    while (!done && n < 20) begin n++; @(negedge clk); end
    chk("b2b_spacing", n, 5);
    chk("b2b_sum2", sum, r2[15:0]);
    chk("b2b_carry2", carry, cy2);
    last16 = r2[15:0];

    // Reset after two slices of an operation.
    @(negedge clk);
    A = 16'h1234; B = 16'h4321; C = 0; sub = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_carry", carry, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_zero", zero, 1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    last16 = '0;
    last8  = '0;
    op16(16'h0001, 16'h0001, 0, 0, 0, "after_rst");

    op8(8'h80, 8'h80, 0, 0, "n1_ovf");
    for (int i = 0; i < 10; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "n1_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
